// File: rtl/arb_pkg.sv
// Shared types for the stream arbitration blocks.
package arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational first-requester search, starting at ptr (round-robin) or at index 0.
module rr_arbiter #(
    parameter int unsigned N           = 4,
    parameter bit          ROUND_ROBIN = 1'b1,
    localparam int unsigned CW         = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [CW-1:0] base;
    logic [N-1:0]  rot;
    int unsigned   sum;

    always_comb begin
        base    = ROUND_ROBIN ? ptr : '0;
        // Doubling the request vector lets a plain shift implement the wrap.
        rot     = N'({req, req} >> base);
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = 0;
        // Descending scan so the lowest offset from base is the final winner.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_any = 1'b1;
                sum     = int'(base) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                gnt_idx = CW'(sum);
            end
        end
    end

endmodule

// File: rtl/arb_stream_mux.sv
// N-to-1 valid/ready stream mux with packet locking and a registered output beat.
module arb_stream_mux
    import arb_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned W           = 8,
    parameter bit          ROUND_ROBIN = 1'b1,
    localparam int unsigned CW         = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [CW-1:0]  out_sel,
    output logic           busy
);

    arb_state_t    state_q;
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] lock_q;

    logic [CW-1:0] gnt_idx;
    logic          gnt_any;
    logic [CW-1:0] sel;
    logic          sel_ok;
    logic          slot_free;
    logic          xfer;
    logic [W-1:0]  sel_data;
    logic          sel_last;
    logic [CW-1:0] ptr_d;

    rr_arbiter #(
        .N          (N),
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb (
        .req    (in_valid),
        .ptr    (ptr_q),
        .gnt_idx(gnt_idx),
        .gnt_any(gnt_any)
    );

    always_comb begin
        slot_free = !out_valid || out_ready;
        sel       = (state_q == LOCKED) ? lock_q : gnt_idx;
        sel_ok    = (state_q == LOCKED) || gnt_any;
        in_ready  = '0;
        // Gated by rst_n so no channel sees a handshake while held in reset.
        if (rst_n && sel_ok && slot_free) begin
            in_ready[sel] = 1'b1;
        end
        xfer     = |(in_valid & in_ready);
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == sel) begin
                sel_data = in_data[i*W +: W];
                sel_last = in_last[i];
            end
        end
        ptr_d = (sel == CW'(N - 1)) ? '0 : sel + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            lock_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_sel   <= sel;
            ptr_q     <= ptr_d;
            if (state_q == IDLE) begin
                if (!sel_last) begin
                    lock_q  <= sel;
                    state_q <= LOCKED;
                end
            end else if (sel_last) begin
                state_q <= IDLE;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state_q == LOCKED);

endmodule

// File: tb/tb_arb_stream_mux.sv
// Checks a round-robin N=4 mux and a fixed-priority N=3 mux against a beat-level reference model.
module tb_arb_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] v     [2];
    logic [3:0] l     [2];
    logic [7:0] dat   [2][4];
    logic       ordy  [2];

    logic [3:0] ir0;
    logic       ov0, ol0, busy0;
    logic [7:0] od0;
    logic [1:0] os0;
    logic [2:0] ir1;
    logic       ov1, ol1, busy1;
    logic [7:0] od1;
    logic [1:0] os1;

    arb_stream_mux #(.N(4), .W(8), .ROUND_ROBIN(1'b1)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (v[0]),
        .in_ready (ir0),
        .in_data  ({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}),
        .in_last  (l[0]),
        .out_valid(ov0),
        .out_ready(ordy[0]),
        .out_data (od0),
        .out_last (ol0),
        .out_sel  (os0),
        .busy     (busy0)
    );

    arb_stream_mux #(.N(3), .W(8), .ROUND_ROBIN(1'b0)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (v[1][2:0]),
        .in_ready (ir1),
        .in_data  ({dat[1][2], dat[1][1], dat[1][0]}),
        .in_last  (l[1][2:0]),
        .out_valid(ov1),
        .out_ready(ordy[1]),
        .out_data (od1),
        .out_last (ol1),
        .out_sel  (os1),
        .busy     (busy1)
    );

    logic [3:0] o_ir [2];
    logic       o_ov [2];
    logic [7:0] o_od [2];
    logic       o_ol [2];
    logic [1:0] o_os [2];
    logic       o_bs [2];
    assign o_ir[0] = ir0;
    assign o_ir[1] = {1'b0, ir1};
    assign o_ov[0] = ov0;
    assign o_ov[1] = ov1;
    assign o_od[0] = od0;
    assign o_od[1] = od1;
    assign o_ol[0] = ol0;
    assign o_ol[1] = ol1;
    assign o_os[0] = os0;
    assign o_os[1] = os1;
    assign o_bs[0] = busy0;
    assign o_bs[1] = busy1;

    int nch [2] = '{4, 3};
    bit rr  [2] = '{1'b1, 1'b0};

    // Reference model: the beat the output register should hold and the arbitration state.
    int         m_ptr    [2];
    int         m_lock   [2];
    bit         m_locked [2];
    bit         m_ov     [2];
    logic [7:0] m_od     [2];
    logic       m_ol     [2];
    int         m_os     [2];
    int         last_g   [2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]    = 0;
            m_lock[d]   = 0;
            m_locked[d] = 1'b0;
            m_ov[d]     = 1'b0;
            m_od[d]     = '0;
            m_ol[d]     = 1'b0;
            m_os[d]     = 0;
            last_g[d]   = -1;
        end
    endtask

    function automatic int grant(input int d);
        int c;
        if (m_locked[d]) return m_lock[d];
        for (int k = 0; k < nch[d]; k++) begin
            c = rr[d] ? (m_ptr[d] + k) % nch[d] : k;
            if (v[d][c]) return c;
        end
        return -1;
    endfunction

    // One clock: check in_ready before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        int         g  [2];
        bit         xf [2];
        logic [7:0] pd [2];
        logic       pl [2];
        logic [3:0] er;
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d]  = grant(d);
            er    = '0;
            xf[d] = 1'b0;
            pd[d] = '0;
            pl[d] = 1'b0;
            if (g[d] >= 0 && (!m_ov[d] || ordy[d])) begin
                er[g[d]] = 1'b1;
                xf[d]    = v[d][g[d]];
                pd[d]    = dat[d][g[d]];
                pl[d]    = l[d][g[d]];
            end
            chk($sformatf("in_ready%0d", d), 32'(o_ir[d]), 32'(er));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            last_g[d] = -1;
            if (xf[d]) begin
                m_ov[d]  = 1'b1;
                m_od[d]  = pd[d];
                m_ol[d]  = pl[d];
                m_os[d]  = g[d];
                m_ptr[d] = (g[d] + 1) % nch[d];
                if (m_locked[d]) begin
                    if (pl[d]) m_locked[d] = 1'b0;
                end else if (!pl[d]) begin
                    m_locked[d] = 1'b1;
                    m_lock[d]   = g[d];
                end
                v[d][g[d]] = 1'b0;
                last_g[d]  = g[d];
            end else if (ordy[d]) begin
                m_ov[d] = 1'b0;
            end
            chk($sformatf("out_valid%0d", d), 32'(o_ov[d]), 32'(m_ov[d]));
            chk($sformatf("out_data%0d", d), 32'(o_od[d]), 32'(m_od[d]));
            chk($sformatf("out_last%0d", d), 32'(o_ol[d]), 32'(m_ol[d]));
            chk($sformatf("out_sel%0d", d), 32'(o_os[d]), 32'(m_os[d]));
            chk($sformatf("busy%0d", d), 32'(o_bs[d]), 32'(m_locked[d]));
        end
    endtask

    int         rr_seq   [5] = '{0, 1, 2, 3, 0};
    int         rr_occ   [5] = '{0, 0, 0, 0, 1};
    int         lk_sel   [4] = '{2, 2, 2, 0};
    logic [7:0] lk_dat   [4] = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
    bit         lk_busy  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v[d]    = (d == 0) ? 4'hF : 4'h7;
            l[d]    = 4'hF;
            ordy[d] = 1'b1;
            for (int c = 0; c < 4; c++) dat[d][c] = 8'(c * 16);
        end
        model_reset();

        // Held in reset with every channel requesting.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_in_ready%0d", d), 32'(o_ir[d]), 32'h0);
            chk($sformatf("rst_out_valid%0d", d), 32'(o_ov[d]), 32'h0);
            chk($sformatf("rst_out_data%0d", d), 32'(o_od[d]), 32'h0);
            chk($sformatf("rst_out_sel%0d", d), 32'(o_os[d]), 32'h0);
            chk($sformatf("rst_busy%0d", d), 32'(o_bs[d]), 32'h0);
        end
        v[1] = 4'h0;
        #1 rst_n = 1'b1;

        // Round-robin with continuous single-beat packets on all channels.
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_sel", 32'(os0), 32'(rr_seq[i]));
            chk("rr_data", 32'(od0), 32'(rr_seq[i] * 16 + rr_occ[i]));
            chk("rr_valid", 32'(ov0), 32'h1);
            if (last_g[0] >= 0) begin
                v[0][last_g[0]]   = 1'b1;
                dat[0][last_g[0]] = dat[0][last_g[0]] + 8'd1;
            end
        end

        // Locking: ch2 three-beat packet while ch0 waits.
        v[0]      = 4'b0101;
        l[0]      = 4'b0001;
        dat[0][2] = 8'hA0;
        dat[0][0] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("lock_sel", 32'(os0), 32'(lk_sel[i]));
            chk("lock_data", 32'(od0), 32'(lk_dat[i]));
            chk("lock_busy", 32'(busy0), 32'(lk_busy[i]));
            if (i < 2) begin
                v[0][2]   = 1'b1;
                dat[0][2] = lk_dat[i+1];
                l[0][2]   = (i == 1);
            end
        end

        // Back-pressure with a pending output beat.
        v[0]      = 4'b1010;
        l[0]      = 4'b1111;
        dat[0][1] = 8'h77;
        dat[0][3] = 8'h33;
        cycle();
        chk("bp_first", 32'(od0), 32'h77);
        ordy[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_hold_data", 32'(od0), 32'h77);
            chk("bp_hold_valid", 32'(ov0), 32'h1);
            chk("bp_in_ready", 32'(ir0), 32'h0);
        end
        ordy[0] = 1'b1;
        cycle();
        chk("bp_release", 32'(od0), 32'h33);
        cycle();
        chk("bp_drain", 32'(ov0), 32'h0);

        // Fixed priority, N=3: ch1 and ch2 always valid, ch1 always wins.
        v[1]      = 4'b0110;
        l[1]      = 4'b1111;
        dat[1][1] = 8'h11;
        dat[1][2] = 8'h22;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("fp_sel", 32'(os1), 32'h1);
            chk("fp_data", 32'(od1), 32'h11);
            v[1][1] = 1'b1;
        end
        v[1] = 4'h0;
        cycle();

        // Reset in the middle of a ch1 packet.
        v[0]      = 4'b0010;
        l[0]      = 4'b0000;
        dat[0][1] = 8'hB0;
        cycle();
        chk("mid_busy", 32'(busy0), 32'h1);
        v[0][1]   = 1'b1;
        dat[0][1] = 8'hB1;
        #1 rst_n  = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov0), 32'h0);
        chk("mid_rst_busy", 32'(busy0), 32'h0);
        chk("mid_rst_ready", 32'(ir0), 32'h0);
        model_reset();
        v[0] = 4'b1111;
        l[0] = 4'b1101;
        for (int c = 0; c < 4; c++) if (c != 1) dat[0][c] = 8'(8'hC0 + c);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cycle();
        chk("mid_restart_sel", 32'(os0), 32'h0);
        chk("mid_restart_busy", 32'(busy0), 32'h0);
        cycle();
        chk("mid_newpkt_sel", 32'(os0), 32'h1);
        chk("mid_newpkt_busy", 32'(busy0), 32'h1);
        cycle();
        v[0][1]   = 1'b1;
        l[0][1]   = 1'b1;
        dat[0][1] = 8'hB2;
        cycle();
        chk("mid_end_busy", 32'(busy0), 32'h0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < nch[d]; c++) begin
                    if (!v[d][c] && $urandom_range(1, 0) == 1) begin
                        v[d][c]   = 1'b1;
                        dat[d][c] = 8'($urandom);
                        l[d][c]   = ($urandom_range(2, 0) == 0);
                    end
                end
                ordy[d] = ($urandom_range(3, 0) != 0);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_stream_mux.md
# arb_stream_mux

Parametrised N-channel stream multiplexer with valid/ready handshakes, packet locking and a registered output stage. It selects one of `N` `W`-bit input streams under round-robin or fixed-priority arbitration and holds the grant until the granted channel's `last` beat is accepted. It sits wherever several producers share one downstream consumer. Examples are UART TX sources and display/LED data paths. It replaces the combinational `mux2`/`mux4` selectors where flow control is needed.

## Interface
Parameters:
- `N`, 4: number of input channels; N ≥ 2, need not be a power of two.
- `W`, 8: data width per channel.
- `ROUND_ROBIN`, 1: 1 selects round-robin; 0 selects fixed priority, where the lowest index wins.
- `CW`, `$clog2(N)`: derived localparam for the select width; not overridable.

Ports:
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in N: per-channel beat valid.
- `in_ready` out N: per-channel beat accepted; combinational.
- `in_data` in N*W: flattened data; channel i occupies bits [i*W +: W].
- `in_last` in N: final beat of a packet, per channel.
- `out_valid` out 1: registered output beat valid.
- `out_ready` in 1: downstream accepts the output beat.
- `out_data` out W: registered output data.
- `out_last` out 1: registered last flag.
- `out_sel` out CW: index of the channel that produced the current output beat.
- `busy` out 1: high while a multi-beat packet holds the lock.

## Operation
- `slot_free = !out_valid || out_ready`. A beat transfers from channel g when `in_valid[g] && in_ready[g]`. At most one channel transfers per cycle.
- FSM has two states, IDLE and LOCKED. The enum lives in the shared package.
- IDLE:
  - Grant g is the first requesting channel.
  - Round-robin searches from `ptr` upward, wrapping from N-1 to 0.
  - Fixed priority searches from index 0.
  - `in_ready[g] = slot_free`; every other `in_ready` is 0.
  - On transfer, `ptr <= (g+1) mod N`, in both modes; `ptr` is simply unused when ROUND_ROBIN=0.
  - If `in_last[g]` is set, stay in IDLE. Otherwise `lock <= g` and move to LOCKED.
- LOCKED:
  - `in_ready[lock] = slot_free`; all other channels are stalled regardless of their valid.
  - A transfer with `in_last` returns the FSM to IDLE.
  - If `in_valid[lock]` is low, the FSM waits indefinitely. There is no timeout.
- Output register:
  - On transfer: `out_data <= in_data[g]`, `out_last <= in_last[g]`, `out_sel <= g`, `out_valid <= 1`.
  - Else, if `out_ready`: `out_valid <= 0`.
  - Data, last and sel hold their values when not loaded.
- `busy = (state == LOCKED)`.
- Upstream contract: once a channel asserts valid, it must hold valid and data stable until the beat is accepted. The block does not check this.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`, `busy=0`, `in_ready=0`, `ptr=0`, `lock=0`, state IDLE.
- Latency is 1 cycle from input transfer to `out_valid`. Throughput is 1 beat/cycle while `out_ready` stays high.
- There is a combinational path from `out_ready` and `in_valid` to `in_ready`; there is no path from input data to any output.
- Simultaneous events:
  - When downstream consumes the output beat and a new beat loads in the same cycle, `out_valid` stays 1 and the register takes the new beat.
  - If the request at `ptr` is itself valid, it wins.
- Back-pressure: with `out_valid=1` and `out_ready=0`, all `in_ready` are 0 and the FSM and `ptr` are frozen.
- Reset mid-packet:
  - Lock, FSM and output beat are discarded immediately, asynchronously.
  - The next grant restarts arbitration from `ptr=0`.
  - The remainder of the packet is treated as a new packet.
- Single-beat packets (`last` on the first beat) never enter LOCKED.

## Structure
- Shared package `arb_pkg`: FSM state enum `arb_state_t` {IDLE, LOCKED}.
- Sub-module `rr_arbiter`:
  - Parameters `N`, `ROUND_ROBIN`.
  - Inputs: `req` [N], `ptr` [CW].
  - Outputs: `gnt_idx` [CW], `gnt_any`.
  - Purely combinational, using a double-width request vector for the wrap.
  - Reused later by other multi-source blocks.
- Top level holds the FSM, `ptr`/`lock` registers and the output register.

## Test plan
- Reset: hold `rst_n=0` with channels valid -> all outputs 0 and `in_ready=0`. Release -> first grant goes to channel 0.
- Round-robin, N=4, W=8: all channels send continuous single-beat packets, `out_ready=1` -> `out_sel` sequence is 0,1,2,3,0 and `out_data` matches each source; one beat per cycle.
- Locking: ch2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last) while ch0 is valid -> three ch2 beats are contiguous, then ch0. `busy` is high from the cycle after the first ch2 beat until the cycle after the last-beat transfer.
- Back-pressure: `out_ready=0` for 5 cycles with an output beat pending -> `out_valid`/`out_data` are stable, all `in_ready=0`, and no beat is lost or duplicated on release.
- Fixed priority, ROUND_ROBIN=0, N=3: ch1 and ch2 are always valid -> ch1 wins every arbitration and ch2 is starved. Non-power-of-two N is exercised, and `out_sel` never reaches 3.
- Reset mid-packet: assert `rst_n` low during the 2nd beat of a ch1 packet -> `out_valid` drops immediately and after release `busy=0`, state is IDLE and arbitration restarts at ch0.
